// File: rtl/multi_cycle_control.sv
// Multi-cycle control unit: walks each instruction through IF/ID/EXE/MEM/WB,
// drives the datapath control lines and counts retired instructions.
module multi_cycle_control #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [5:0]       opCode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWre,
  output logic             IRWre,
  output logic             ALUSrcB,
  output logic             ALUM2Reg,
  output logic             RegWre,
  output logic             InsMemRW,
  output logic             DataMemRW,
  output logic             ExtSel,
  output logic             PCSrc,
  output logic             RegOut,
  output logic [2:0]       ALUOp,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EXE  = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_OR   = 6'b010010;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic [5:0] op_q;
  logic [5:0] dec_op;
  logic [2:0] state_nxt;

  // State and latched opcode
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= S_IF;
      op_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_ID) op_q <= opCode;
    end
  end

  // Saturating retired-instruction counter
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      retired <= '0;
    end else if (PCWre && (retired != {CNT_W{1'b1}})) begin
      retired <= retired + CNT_W'(1);
    end
  end

  // Next state and control decode; op_q is not loaded until the end of ID,
  // so ID decodes straight from the instruction register.
  always_comb begin
    state_nxt = S_IF;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    InsMemRW  = 1'b0;
    DataMemRW = 1'b0;
    PCSrc     = 1'b0;
    ALUSrcB   = 1'b0;
    ALUM2Reg  = 1'b0;
    ExtSel    = 1'b0;
    RegOut    = 1'b0;
    ALUOp     = 3'b000;
    halted    = 1'b0;
    dec_op    = (state == S_ID) ? opCode : op_q;

    case (state)
      S_IF: begin
        IRWre     = 1'b1;
        state_nxt = S_ID;
      end
      S_ID: state_nxt = (opCode == OP_HALT) ? S_HALT : S_EXE;
      S_EXE: begin
        if (op_q == OP_BEQ) begin
          PCSrc     = zero;
          PCWre     = 1'b1;
          state_nxt = S_IF;
        end else if ((op_q == OP_SW) || (op_q == OP_LW)) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        DataMemRW = (op_q == OP_SW);
        if (!mem_ready)          state_nxt = S_MEM;
        else if (op_q == OP_SW) begin
          PCWre     = 1'b1;
          state_nxt = S_IF;
        end else                 state_nxt = S_WB;
      end
      S_WB: begin
        RegWre    = (op_q == OP_ADD) || (op_q == OP_ADDI) || (op_q == OP_SUB) ||
                    (op_q == OP_ORI) || (op_q == OP_AND)  || (op_q == OP_OR)  ||
                    (op_q == OP_LW);
        PCWre     = 1'b1;
        state_nxt = S_IF;
      end
      S_HALT: begin
        halted    = 1'b1;
        state_nxt = S_HALT;
      end
      default: state_nxt = S_IF;
    endcase

    if ((state == S_ID) || (state == S_EXE) || (state == S_MEM) || (state == S_WB)) begin
      ALUSrcB  = (dec_op == OP_ADDI) || (dec_op == OP_ORI) || (dec_op == OP_SW) || (dec_op == OP_LW);
      ALUM2Reg = (dec_op == OP_LW);
      ExtSel   = (dec_op != OP_ORI);
      RegOut   = !((dec_op == OP_ADDI) || (dec_op == OP_ORI) || (dec_op == OP_LW));
      if (dec_op == OP_AND)                              ALUOp = 3'b100;
      else if ((dec_op == OP_ORI) || (dec_op == OP_OR))  ALUOp = 3'b011;
      else if ((dec_op == OP_SUB) || (dec_op == OP_BEQ)) ALUOp = 3'b001;
      else                                               ALUOp = 3'b000;
    end

    // Reset kills every enable immediately, even mid-access
    if (!Reset) begin
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      RegWre    = 1'b0;
      DataMemRW = 1'b0;
      PCSrc     = 1'b0;
      halted    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: expected per-cycle controls are
// queued as stimulus is driven and compared on the falling edge.
module tb_multi_cycle_control;

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [5:0] ADD = 6'b000000, ADDI = 6'b000001, SUB = 6'b000010;
  localparam logic [5:0] ORI = 6'b010000, ANDI = 6'b010001, ORR = 6'b010010;
  localparam logic [5:0] SW  = 6'b100110, LW  = 6'b100111, BEQ = 6'b110000;
  localparam logic [5:0] HLT = 6'b111111, UND = 6'b001111;

  logic             CLK = 1'b0;
  logic             Reset = 1'b0;
  logic [5:0]       opCode = '0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             PCWre, IRWre, ALUSrcB, ALUM2Reg, RegWre, InsMemRW;
  logic             DataMemRW, ExtSel, PCSrc, RegOut, halted;
  logic [2:0]       ALUOp, state;
  logic [CNT_W-1:0] retired;

  multi_cycle_control #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .Reset(Reset), .opCode(opCode), .zero(zero), .mem_ready(mem_ready),
    .PCWre(PCWre), .IRWre(IRWre), .ALUSrcB(ALUSrcB), .ALUM2Reg(ALUM2Reg),
    .RegWre(RegWre), .InsMemRW(InsMemRW), .DataMemRW(DataMemRW), .ExtSel(ExtSel),
    .PCSrc(PCSrc), .RegOut(RegOut), .ALUOp(ALUOp), .state(state), .halted(halted),
    .retired(retired)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [16:0]      vec;
    logic [CNT_W-1:0] ret;
    string            tag;
  } exp_t;

  exp_t             sb[$];
  exp_t             cur;
  logic [CNT_W-1:0] exp_ret = '0;
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // {state, PCWre, IRWre, RegWre, DataMemRW, PCSrc, ALUSrcB, ALUM2Reg, ExtSel, RegOut, ALUOp, halted, InsMemRW}
  function automatic logic [16:0] model(input logic [2:0] st, input logic [5:0] op,
                                        input logic z, input logic mr);
    logic pcw, irw, rw, dm, pcs, asb, am, es, ro, hl;
    logic [2:0] aop;
    pcw = 0; irw = 0; rw = 0; dm = 0; pcs = 0; asb = 0; am = 0; es = 0; ro = 0; hl = 0;
    aop = 3'b000;
    if (st inside {3'd1, 3'd2, 3'd3, 3'd4}) begin
      asb = op inside {ADDI, ORI, SW, LW};
      am  = (op == LW);
      es  = (op != ORI);
      ro  = !(op inside {ADDI, ORI, LW});
      aop = (op == ANDI) ? 3'b100 : (op inside {ORI, ORR}) ? 3'b011 :
            (op inside {SUB, BEQ}) ? 3'b001 : 3'b000;
    end
    case (st)
      3'd0: irw = 1;
      3'd2: if (op == BEQ) begin pcw = 1; pcs = z; end
      3'd3: begin dm = (op == SW); pcw = mr && (op == SW); end
      3'd4: begin rw = op inside {ADD, ADDI, SUB, ORI, ANDI, ORR, LW}; pcw = 1; end
      3'd5: hl = 1;
      default: ;
    endcase
    return {st, pcw, irw, rw, dm, pcs, asb, am, es, ro, aop, hl, 1'b0};
  endfunction

  // One clock of stimulus plus its expected response
  task automatic cycle(input logic rst, input logic [5:0] op, input logic z, input logic mr,
                       input logic [2:0] st, input string tag, output logic pcw);
    exp_t e;
    @(posedge CLK);
    #1;
    Reset = rst; opCode = op; zero = z; mem_ready = mr;
    if (!rst) exp_ret = '0;
    e.vec = rst ? model(st, op, z, mr) : 17'd0;
    e.ret = exp_ret;
    e.tag = tag;
    sb.push_back(e);
    pcw = e.vec[13];
    if (pcw && (exp_ret != CNT_MAX)) exp_ret = exp_ret + CNT_W'(1);
  endtask

  task automatic do_reset(input int n);
    logic pcw;
    repeat (n) cycle(1'b0, 6'($urandom), 1'($urandom), 1'($urandom), 3'd0, "reset", pcw);
  endtask

  // Run one instruction; cut>0 stops after that many cycles (no retire)
  task automatic run_instr(input logic [5:0] op, input logic z, input int waits,
                           input int cut, input string tag);
    logic [2:0] st = 3'd0;
    logic pcw, mr, zz, done;
    int k = 0, hcnt = 0, wl = waits;
    done = 0;
    while (!done && k < 200) begin
      mr = (st == 3'd3) ? (wl == 0) : 1'($urandom);
      zz = (st == 3'd2) ? z : 1'($urandom);
      cycle(1'b1, op, zz, mr, st, tag, pcw);
      k++;
      case (st)
        3'd0: st = 3'd1;
        3'd1: st = (op == HLT) ? 3'd5 : 3'd2;
        3'd2: st = (op == BEQ) ? 3'd0 : (op inside {SW, LW}) ? 3'd3 : 3'd4;
        3'd3: if (mr) st = (op == SW) ? 3'd0 : 3'd4; else wl--;
        3'd4: st = 3'd0;
        default: begin hcnt++; if (hcnt == 22) done = 1; end
      endcase
      if (pcw) done = 1;
      if (cut != 0 && k == cut) done = 1;
    end
  endtask

  always @(negedge CLK) begin
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      check({cur.tag, "/ctl"}, 32'({state, PCWre, IRWre, RegWre, DataMemRW, PCSrc, ALUSrcB,
                                     ALUM2Reg, ExtSel, RegOut, ALUOp, halted, InsMemRW}),
            32'(cur.vec));
      check({cur.tag, "/ret"}, 32'(retired), 32'(cur.ret));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] mix [9] = '{ADD, ADDI, SUB, ORI, ANDI, ORR, BEQ, SW, LW};
    do_reset(3);
    run_instr(ADD, 1'b0, 0, 0, "add");
    run_instr(BEQ, 1'b1, 0, 0, "beq_z1");
    run_instr(BEQ, 1'b0, 0, 0, "beq_z0");
    run_instr(LW,  1'b0, 2, 0, "lw_w2");
    run_instr(SW,  1'b0, 0, 0, "sw_w0");
    run_instr(UND, 1'b0, 0, 0, "undef");
    run_instr(ORI, 1'b0, 0, 0, "ori");
    run_instr(HLT, 1'b0, 0, 0, "halt");
    do_reset(2);
    run_instr(SW,  1'b0, 3, 4, "sw_cut");
    do_reset(2);
    for (int i = 0; i < 18; i++)
      run_instr(mix[$urandom_range(0, 8)], 1'($urandom), $urandom_range(0, 2), 0, "sat");
    run_instr(ADD, 1'b0, 0, 0, "sat_end");
    @(posedge CLK);
    repeat (2) @(negedge CLK);
    check("sat_final", 32'(retired), 32'(CNT_MAX));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- Multi-cycle replacement for the single-cycle control decoder. Same opcode set, same datapath control signals.
- Sequences each instruction through IF/ID/EXE/MEM/WB states. Adds an instruction-register write enable and a data-memory ready handshake.
- Pulses PCWre exactly once per retired instruction. Sits between the instruction register and the existing datapath muxes, register file and memories.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- opCode  input  6  opcode field from the instruction register; valid from the ID state onward.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  data memory has completed the current access.
- PCWre  output  1  PC load enable, one-cycle pulse at instruction retire.
- IRWre  output  1  instruction register load enable.
- ALUSrcB, ALUM2Reg, RegWre, InsMemRW, DataMemRW, ExtSel, PCSrc, RegOut  output  1 each  datapath controls, encodings unchanged from the single-cycle decoder.
- ALUOp  output  3  ALU function select.
- state  output  3  current state, for debug.
- halted  output  1  high in the HALT state.
- retired  output  CNT_W  count of retired instructions.

Behaviour:
- State encodings: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 return to IF on the next edge.
- While Reset=0:
  - state=IF, op_q=0, retired=0.
  - All enables forced to 0: PCWre, IRWre, RegWre, DataMemRW, PCSrc.
  - halted=0.
- Transitions and per-state enables:
  - IF: IRWre=1, InsMemRW=0. Next state ID.
  - ID: op_q<=opCode. If opCode=111111 go to HALT, else EXE.
  - EXE:
    - beq (110000): PCSrc=zero, PCWre=1, next IF.
    - sw (100110) or lw (100111): next MEM.
    - All other opcodes: next WB.
  - MEM:
    - Stay in MEM while mem_ready=0.
    - sw: DataMemRW=1 throughout MEM (1=write, 0=read). When mem_ready=1: PCWre=1, next IF.
    - lw: DataMemRW=0. When mem_ready=1: next WB.
  - WB:
    - RegWre=1 for add 000000, addi 000001, sub 000010, ori 010000, and 010001, or 010010, lw.
    - Undefined opcodes get RegWre=0, so they behave as a nop.
    - PCWre=1, next IF.
  - HALT: all enables 0, halted=1. Left only by Reset.
- Static decode from op_q (levels in ID through WB; 0 in IF):
  - ALUSrcB=1 for addi, ori, sw, lw.
  - ALUM2Reg=1 for lw.
  - ExtSel=0 for ori, else 1.
  - RegOut=0 for addi, ori, lw, else 1.
  - ALUOp: and=100, ori=011, or=011, sub=001, beq=001, all others 000.
- Only PCWre, PCSrc and DataMemRW depend combinationally on zero or mem_ready. Every other output depends on state and op_q only.
- PCSrc is 1 only in EXE for beq with zero=1; otherwise 0.
- Latency from IF entry to PCWre pulse:
  - beq: 3 cycles.
  - ALU ops and undefined opcodes: 4 cycles.
  - sw: 4+w cycles; lw: 5+w cycles, where w = number of mem_ready=0 cycles.
- retired: increments on each cycle with PCWre=1. Saturates at all-ones and does not wrap. Not incremented by halt.
- Simultaneous events:
  - mem_ready=1 on the first MEM cycle: zero wait.
  - mem_ready outside MEM: ignored.
  - zero outside EXE: ignored.
- Reset mid-instruction or mid-wait:
  - Immediate return to IF with all enables 0.
  - No partial register write or memory write may leak after Reset falls.

Test Plan:
- Reset low for 3 cycles, then release → state 0,1,2,4,0 for add. IRWre=1 only in IF. RegWre=1 and PCWre=1 only in WB. retired=1.
- beq with zero=1 → PCSrc=1 and PCWre=1 in EXE, ALUOp=001, back to IF after 3 cycles. Same with zero=0 → PCSrc=0, PCWre=1.
- lw with mem_ready held 0 for 2 MEM cycles → MEM lasts 3 cycles with DataMemRW=0, ALUSrcB=1, ALUM2Reg=1. WB has RegWre=1, RegOut=0. Total 7 cycles.
- sw with mem_ready=1 immediately → DataMemRW=1 for exactly 1 cycle, PCWre pulses in MEM, RegWre stays 0 throughout.
- ori then opcode 111111 → ori gives ExtSel=0, ALUOp=011 in ID–WB. Halt reaches HALT after ID, halted=1 for 20+ cycles, retired stays 1.
- Reset asserted in the second MEM wait cycle of sw → DataMemRW drops immediately, state=0. Counter forced to all-ones minus 1, then two instructions retired → retired saturates at all-ones.
